// File: rtl/lsu_ctrl.sv
// lsu_ctrl: load/store unit controller between a single-issue pipeline and a
// byte-addressed data memory. It decodes RV32I load/store width codes,
// rejects illegal, misaligned and out-of-range accesses, issues one memory
// command per access and returns extended load data through a valid/ready
// response handshake. Every output comes straight from a flop.

module lsu_ctrl #(
  parameter int unsigned MEM_BYTES = 128
) (
  input  logic                           clk,
  input  logic                           reset,
  input  logic                           req_valid,
  output logic                           req_ready,
  input  logic                           req_we,
  input  logic [2:0]                     req_funct3,
  input  logic [31:0]                    req_addr,
  input  logic [31:0]                    req_wdata,
  output logic                           rsp_valid,
  input  logic                           rsp_ready,
  output logic [31:0]                    rsp_rdata,
  output logic                           rsp_err,
  output logic [1:0]                     mem_rwe,
  output logic [$clog2(MEM_BYTES)-1:0]   mem_addr,
  output logic [31:0]                    mem_wdata,
  input  logic [31:0]                    mem_rdata
);

  localparam int unsigned AW = $clog2(MEM_BYTES);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    ST_WR   = 3'd1,
    LD_ADDR = 3'd2,
    LD_DATA = 3'd3,
    RESP    = 3'd4
  } state_t;

  // Store width code to memory command; 0 marks an illegal store code.
  function automatic logic [1:0] f_store_code(input logic [2:0] f3);
    case (f3)
      3'b000:  return 2'd3;
      3'b001:  return 2'd2;
      3'b010:  return 2'd1;
      default: return 2'd0;
    endcase
  endfunction

  // Legal RV32I load width/sign codes.
  function automatic logic f_load_legal(input logic [2:0] f3);
    case (f3)
      3'b000, 3'b001, 3'b010, 3'b100, 3'b101: return 1'b1;
      default:                                return 1'b0;
    endcase
  endfunction

  // Size field 01 is a halfword, 10 a word; bytes are never misaligned.
  function automatic logic f_misaligned(input logic [1:0] size, input logic [1:0] a);
    case (size)
      2'b01:   return a[0];
      2'b10:   return (a != 2'b00);
      default: return 1'b0;
    endcase
  endfunction

  // Memory returns the addressed byte in [7:0]; only access-width bits are used.
  function automatic logic [31:0] f_extend(input logic [2:0] f3, input logic [31:0] d);
    case (f3)
      3'b000:  return {{24{d[7]}}, d[7:0]};
      3'b001:  return {{16{d[15]}}, d[15:0]};
      3'b010:  return d;
      3'b100:  return {24'd0, d[7:0]};
      3'b101:  return {16'd0, d[15:0]};
      default: return 32'd0;
    endcase
  endfunction

  state_t         r_state;
  state_t         w_state_nxt;
  logic [2:0]     r_funct3;
  logic [2:0]     w_funct3_nxt;
  logic           r_req_ready;
  logic           w_req_ready_nxt;
  logic [1:0]     r_mem_rwe;
  logic [1:0]     w_mem_rwe_nxt;
  logic [AW-1:0]  r_mem_addr;
  logic [AW-1:0]  w_mem_addr_nxt;
  logic [31:0]    r_mem_wdata;
  logic [31:0]    w_mem_wdata_nxt;
  logic           r_rsp_valid;
  logic           w_rsp_valid_nxt;
  logic [31:0]    r_rsp_rdata;
  logic [31:0]    w_rsp_rdata_nxt;
  logic           r_rsp_err;
  logic           w_rsp_err_nxt;

  logic           w_accept;
  logic [1:0]     w_st_code;
  logic           w_req_err;

  assign w_accept  = req_valid & r_req_ready;
  assign w_st_code = f_store_code(req_funct3);
  assign w_req_err = (req_we ? (w_st_code == 2'd0) : !f_load_legal(req_funct3))
                   | f_misaligned(req_funct3[1:0], req_addr[1:0])
                   | (|req_addr[31:AW]);

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-output decode; the memory command defaults to read/idle
  // so a store command can only ever last the single cycle spent in ST_WR.
  always_comb begin
    w_state_nxt     = r_state;
    w_funct3_nxt    = r_funct3;
    w_mem_rwe_nxt   = 2'd0;
    w_mem_addr_nxt  = r_mem_addr;
    w_mem_wdata_nxt = r_mem_wdata;
    w_rsp_valid_nxt = r_rsp_valid;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_rsp_err_nxt   = r_rsp_err;
    case (r_state)
      IDLE: begin
        if (w_accept) begin
          w_funct3_nxt = req_funct3;
          if (w_req_err) begin
            w_state_nxt     = RESP;
            w_rsp_valid_nxt = 1'b1;
            w_rsp_err_nxt   = 1'b1;
            w_rsp_rdata_nxt = 32'd0;
          end else if (req_we) begin
            w_state_nxt     = ST_WR;
            w_mem_rwe_nxt   = w_st_code;
            w_mem_addr_nxt  = req_addr[AW-1:0];
            w_mem_wdata_nxt = req_wdata;
          end else begin
            w_state_nxt    = LD_ADDR;
            w_mem_addr_nxt = req_addr[AW-1:0];
          end
        end else begin
          w_state_nxt = IDLE;
        end
      end
      ST_WR: begin
        w_state_nxt     = RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = 32'd0;
      end
      LD_ADDR: begin
        w_state_nxt = LD_DATA;
      end
      LD_DATA: begin
        w_state_nxt     = RESP;
        w_rsp_valid_nxt = 1'b1;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = f_extend(r_funct3, mem_rdata);
      end
      RESP: begin
        if (rsp_ready) begin
          w_state_nxt     = IDLE;
          w_rsp_valid_nxt = 1'b0;
          w_rsp_err_nxt   = 1'b0;
          w_rsp_rdata_nxt = 32'd0;
        end else begin
          w_state_nxt = RESP;
        end
      end
      default: begin
        w_state_nxt     = IDLE;
        w_rsp_valid_nxt = 1'b0;
        w_rsp_err_nxt   = 1'b0;
        w_rsp_rdata_nxt = 32'd0;
      end
    endcase
    w_req_ready_nxt = (w_state_nxt == IDLE);
  end

  // Output and context registers; req_ready stays low during reset and rises
  // on the first edge after release.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_funct3    <= 3'd0;
      r_req_ready <= 1'b0;
      r_mem_rwe   <= 2'd0;
      r_mem_addr  <= '0;
      r_mem_wdata <= 32'd0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 32'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      r_funct3    <= w_funct3_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_mem_rwe   <= w_mem_rwe_nxt;
      r_mem_addr  <= w_mem_addr_nxt;
      r_mem_wdata <= w_mem_wdata_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_rsp_err   <= w_rsp_err_nxt;
    end
  end

  assign req_ready = r_req_ready;
  assign mem_rwe   = r_mem_rwe;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = r_mem_wdata;
  assign rsp_valid = r_rsp_valid;
  assign rsp_rdata = r_rsp_rdata;
  assign rsp_err   = r_rsp_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: table-driven bench for lsu_ctrl with a byte-array memory model,
// a response scoreboard queue and hand-written reset-abandon sequences.

module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [1:0]  mem_rwe;
  logic [6:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl #(.MEM_BYTES(128)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_rdata  (rsp_rdata),
    .rsp_err    (rsp_err),
    .mem_rwe    (mem_rwe),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  // Memory model: byte array, registered little-endian read, 1/2/4-byte writes.
  logic [7:0] mem [0:127];
  logic       pre_en;
  logic [6:0] pre_a;
  logic [7:0] pre_d;

  always @(posedge clk) begin
    if (pre_en) begin
      mem[pre_a] <= pre_d;
    end else begin
      case (mem_rwe)
        2'd1: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 7'd1] <= mem_wdata[15:8];
          mem[mem_addr + 7'd2] <= mem_wdata[23:16];
          mem[mem_addr + 7'd3] <= mem_wdata[31:24];
        end
        2'd2: begin
          mem[mem_addr]        <= mem_wdata[7:0];
          mem[mem_addr + 7'd1] <= mem_wdata[15:8];
        end
        2'd3: mem[mem_addr] <= mem_wdata[7:0];
        default: mem_rdata <= {mem[mem_addr + 7'd3], mem[mem_addr + 7'd2],
                               mem[mem_addr + 7'd1], mem[mem_addr]};
      endcase
    end
  end

  // Count cycles with a nonzero memory command and remember the last code.
  int         rwe_cnt;
  logic [1:0] rwe_last;
  always @(posedge clk) begin
    if (mem_rwe != 2'd0) begin
      rwe_cnt  <= rwe_cnt + 1;
      rwe_last <= mem_rwe;
    end
  end

  int n_checks;
  int n_errors;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [2:0]  f3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] rdata;
    logic        err;
    int          lat;
    logic [1:0]  rwe;
    int          hold;
  } vec_t;

  typedef struct packed {
    logic [31:0] rdata;
    logic        err;
    logic [7:0]  lat;
  } exp_t;

  vec_t vecs[$];
  exp_t sb[$];

  task automatic check_all_zero(input string tag);
    chk({tag, ".mem_rwe"},   {30'd0, mem_rwe},   32'd0);
    chk({tag, ".mem_addr"},  {25'd0, mem_addr},  32'd0);
    chk({tag, ".mem_wdata"}, mem_wdata,          32'd0);
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".rsp_rdata"}, rsp_rdata,          32'd0);
    chk({tag, ".rsp_err"},   {31'd0, rsp_err},   32'd0);
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd0);
  endtask

  // Runs one access starting and ending at a negative edge.
  task automatic run_vec(input vec_t v, input string tag);
    exp_t e;
    int   lat;
    int   c0;
    logic [7:0] lat8;
    chk({tag, ".req_ready"}, {31'd0, req_ready}, 32'd1);
    lat8 = v.lat[7:0];
    sb.push_back('{v.rdata, v.err, lat8});
    c0         = rwe_cnt;
    req_valid  = 1'b1;
    req_we     = v.we;
    req_funct3 = v.f3;
    req_addr   = v.addr;
    req_wdata  = v.wdata;
    @(posedge clk);
    @(negedge clk);
    req_valid  = 1'b0;
    req_we     = ~v.we;
    req_funct3 = 3'($urandom_range(0, 7));
    req_addr   = $urandom;
    req_wdata  = $urandom;
    lat = 1;
    while (!rsp_valid && lat < 16) begin
      @(negedge clk);
      lat++;
    end
    chk({tag, ".rsp_valid"}, {31'd0, rsp_valid}, 32'd1);
    e = sb.pop_front();
    chk({tag, ".latency"},   lat,                32'(e.lat));
    chk({tag, ".rsp_rdata"}, rsp_rdata,          e.rdata);
    chk({tag, ".rsp_err"},   {31'd0, rsp_err},   {31'd0, e.err});
    chk({tag, ".busy_ready"}, {31'd0, req_ready}, 32'd0);
    for (int k = 0; k < v.hold; k++) begin
      @(negedge clk);
      chk({tag, ".hold_valid"}, {31'd0, rsp_valid}, 32'd1);
      chk({tag, ".hold_rdata"}, rsp_rdata,          e.rdata);
      chk({tag, ".hold_ready"}, {31'd0, req_ready}, 32'd0);
    end
    rsp_ready = 1'b1;
    @(negedge clk);
    rsp_ready = 1'b0;
    chk({tag, ".drain_valid"}, {31'd0, rsp_valid}, 32'd0);
    chk({tag, ".drain_ready"}, {31'd0, req_ready}, 32'd1);
    chk({tag, ".rwe_cycles"}, rwe_cnt - c0, (v.rwe != 2'd0) ? 32'd1 : 32'd0);
    if (v.rwe != 2'd0) begin
      chk({tag, ".rwe_code"}, {30'd0, rwe_last}, {30'd0, v.rwe});
    end
  endtask

  // Releases reset at a negative edge and checks that nothing is reported.
  task automatic release_and_idle(input string tag);
    reset = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk({tag, ".no_rsp"}, {31'd0, rsp_valid}, 32'd0);
      chk({tag, ".no_wr"},  {30'd0, mem_rwe},   32'd0);
    end
    chk({tag, ".ready"}, {31'd0, req_ready}, 32'd1);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t v;
    n_checks   = 0;
    n_errors   = 0;
    reset      = 1'b0;
    req_valid  = 1'b0;
    req_we     = 1'b0;
    req_funct3 = 3'd0;
    req_addr   = 32'd0;
    req_wdata  = 32'd0;
    rsp_ready  = 1'b0;
    pre_en     = 1'b0;
    pre_a      = 7'd0;
    pre_d      = 8'd0;

    //          we    f3      addr          wdata          rdata          err  lat rwe  hold
    vecs.push_back('{1'b0, 3'b010, 32'd4,        32'd0,         32'h00000010, 1'b0, 3, 2'd0, 4});
    vecs.push_back('{1'b1, 3'b000, 32'd1,        32'h000000AB,  32'h00000000, 1'b0, 2, 2'd3, 0});
    vecs.push_back('{1'b0, 3'b010, 32'd0,        32'd0,         32'h0000AB05, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b1, 3'b001, 32'd8,        32'h0000FF80,  32'h00000000, 1'b0, 2, 2'd2, 0});
    vecs.push_back('{1'b0, 3'b001, 32'd8,        32'd0,         32'hFFFFFF80, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b101, 32'd8,        32'd0,         32'h0000FF80, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b000, 32'd8,        32'd0,         32'hFFFFFF80, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b100, 32'd9,        32'd0,         32'h000000FF, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'd2,        32'd0,         32'h00000000, 1'b1, 1, 2'd0, 0});
    vecs.push_back('{1'b1, 3'b001, 32'd5,        32'h00001111,  32'h00000000, 1'b1, 1, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h80,       32'd0,         32'h00000000, 1'b1, 1, 2'd0, 2});
    vecs.push_back('{1'b1, 3'b010, 32'd12,       32'h12345678,  32'h00000000, 1'b0, 2, 2'd1, 1});
    vecs.push_back('{1'b0, 3'b010, 32'd12,       32'd0,         32'h12345678, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b000, 32'd15,       32'd0,         32'h00000012, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b001, 32'd14,       32'd0,         32'h00001234, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b100, 32'd12,       32'd0,         32'h00000078, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b1, 3'b000, 32'd16,       32'hFFFFFF7E,  32'h00000000, 1'b0, 2, 2'd3, 0});
    vecs.push_back('{1'b0, 3'b010, 32'd16,       32'd0,         32'h0000007E, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b1, 3'b011, 32'd0,        32'hFFFFFFFF,  32'h00000000, 1'b1, 1, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b011, 32'd0,        32'd0,         32'h00000000, 1'b1, 1, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b110, 32'd0,        32'd0,         32'h00000000, 1'b1, 1, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b111, 32'd4,        32'd0,         32'h00000000, 1'b1, 1, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b000, 32'hFFFFFF00, 32'd0,         32'h00000000, 1'b1, 1, 2'd0, 0});
    vecs.push_back('{1'b1, 3'b001, 32'h7E,       32'hFFFF9ABC,  32'h00000000, 1'b0, 2, 2'd2, 0});
    vecs.push_back('{1'b0, 3'b001, 32'h7E,       32'd0,         32'hFFFF9ABC, 1'b0, 3, 2'd0, 0});
    vecs.push_back('{1'b0, 3'b010, 32'h7C,       32'd0,         32'h9ABC0000, 1'b0, 3, 2'd0, 0});

    // Preload memory while the controller is held in reset.
    for (int i = 0; i < 128; i++) begin
      @(negedge clk);
      pre_en = 1'b1;
      pre_a  = 7'(i);
      pre_d  = (i == 0) ? 8'h05 : ((i == 4) ? 8'h10 : 8'h00);
    end
    @(negedge clk);
    pre_en = 1'b0;
    check_all_zero("por");

    reset = 1'b1;
    @(negedge clk);
    chk("post_reset.req_ready", {31'd0, req_ready}, 32'd1);
    chk("post_reset.rsp_valid", {31'd0, rsp_valid}, 32'd0);

    for (int i = 0; i < vecs.size(); i++) begin
      run_vec(vecs[i], $sformatf("v%0d", i));
    end

    // Reset while a store sits in ST_WR: the write must never reach memory.
    req_valid  = 1'b1;
    req_we     = 1'b1;
    req_funct3 = 3'b010;
    req_addr   = 32'd20;
    req_wdata  = 32'hDEADBEEF;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    chk("stwr.mem_rwe",   {30'd0, mem_rwe},   32'd1);
    chk("stwr.mem_wdata", mem_wdata,          32'hDEADBEEF);
    chk("stwr.req_ready", {31'd0, req_ready}, 32'd0);
    reset = 1'b0;
    #1;
    check_all_zero("rst_stwr");
    @(negedge clk);
    release_and_idle("rel_stwr");
    v = '{1'b0, 3'b010, 32'd20, 32'd0, 32'h00000000, 1'b0, 3, 2'd0, 0};
    run_vec(v, "after_stwr");

    // Reset while a load sits in LD_DATA.
    req_valid  = 1'b1;
    req_we     = 1'b0;
    req_funct3 = 3'b010;
    req_addr   = 32'd4;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    chk("lddata.rsp_valid", {31'd0, rsp_valid}, 32'd0);
    chk("lddata.mem_addr",  {25'd0, mem_addr},  32'd4);
    reset = 1'b0;
    #1;
    check_all_zero("rst_lddata");
    @(negedge clk);
    release_and_idle("rel_lddata");
    v = '{1'b0, 3'b010, 32'd4, 32'd0, 32'h00000010, 1'b0, 3, 2'd0, 0};
    run_vec(v, "after_lddata");

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
